seq_1101_tx: RTL and testbench



---
 rtl/seq_1101_tx.sv | 167 ++++++++++++++++
 tb/tb_seq_1101_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_1101_tx.sv
// seq_1101_tx
// Serial frame transmitter for the 1101 sequence-detector link.
// A frame request on `set` latches one byte. The block then drives one bit per
// clock on `out`: the sync word 1101 first, then the byte MSB first. A Moore
// 1101 detector downstream sees the sync word at the start of every frame.
//
// Ports
//   clk    in   system clock; all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   set    in   frame request, level-sampled, acted on only while idle
//   data   in   [7:0] payload byte, captured on the edge that accepts set
//   out    out  serial line, registered, idles at 0
//   busy   out  high while a frame is on the line
//   done   out  one-cycle pulse after the last bit of a frame
//
// Configuration
//   SEQ_1101_TX_PARITY_EN  when defined, an even-parity bit follows d0 and a
//                          frame is 13 bits long. Otherwise a frame is 12 bits.

module seq_1101_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set,
  input  logic [7:0] data,
  output logic       out,
  output logic       busy,
  output logic       done
);

  // The sync word is sent from its MSB down, which gives the order 1,1,0,1.
  localparam logic [3:0] SYNC_WORD = 4'b1101;

`ifdef SEQ_1101_TX_PARITY_EN
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SYNC = 4'b0010,
    DATA = 4'b0100,
    PAR  = 4'b1000
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SYNC = 3'b010,
    DATA = 3'b100
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef SEQ_1101_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  // Each state value names the bit that is on the line in the current cycle.
  // The outputs are therefore computed one edge ahead and registered, so no
  // input reaches an output combinationally. The counter holds the index of
  // the bit now on the line within its section. It restarts on every state
  // entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    out_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_1101_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (set) begin
          state_d = SYNC;
          cnt_d   = 3'd0;
          shift_d = data;
          out_d   = SYNC_WORD[3];
          busy_d  = 1'b1;
`ifdef SEQ_1101_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end

      SYNC: begin
        busy_d = 1'b1;
        if (cnt_q == 3'd3) begin
          state_d = DATA;
          cnt_d   = 3'd0;
          out_d   = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end else begin
          // The next sync bit is index cnt+1 counted from the MSB, which is
          // vector position 2-cnt.
          cnt_d = cnt_q + 3'd1;
          out_d = SYNC_WORD[2'd2 - cnt_q[1:0]];
        end
      end

      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == 3'd7) begin
          cnt_d = 3'd0;
`ifdef SEQ_1101_TX_PARITY_EN
          state_d = PAR;
          out_d   = par_q;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + 3'd1;
          out_d   = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
      end

`ifdef SEQ_1101_TX_PARITY_EN
      PAR: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        done_d  = 1'b1;
      end
`endif

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and output registers. An asynchronous reset drops the line at once
  // and discards any partial frame without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'd0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_1101_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_1101_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_1101_tx.sv
// tb_seq_1101_tx
// Self-checking bench for seq_1101_tx. A reference model describes each frame
// as a queue of bits built from the sync word, the payload byte and optional
// parity. The DUT line is compared with that model every cycle, and whole
// frames are compared with frames computed directly from the payload.

module tb_seq_1101_tx;

`ifdef SEQ_1101_TX_PARITY_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       set   = 1'b0;
  logic [7:0] data  = 8'd0;
  logic       out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit   frameQ[$];
  logic mOut  = 1'b0;
  logic mBusy = 1'b0;
  logic mDone = 1'b0;

  logic [15:0] capBits   = 16'd0;
  int          capLen    = 0;
  int          doneCount = 0;

  seq_1101_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (set),
    .data  (data),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Returns a whole frame for payload d, right-aligned, with the first bit
  // on the line at the most significant position.
  function automatic logic [15:0] expFrame(input logic [7:0] d);
`ifdef SEQ_1101_TX_PARITY_EN
    return {3'b000, 4'b1101, d, ^d};
`else
    return {4'b0000, 4'b1101, d};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the model to the reset state: idle line, no frame pending.
  task automatic modelReset();
    frameQ.delete();
    mOut  = 1'b0;
    mBusy = 1'b0;
    mDone = 1'b0;
  endtask

  // Advances the model by one rising edge, using the inputs seen at that edge.
  task automatic modelEdge();
    if (!rst_n) begin
      modelReset();
    end else if (mBusy) begin
      mDone = 1'b0;
      if (frameQ.size() > 0) begin
        mOut = frameQ.pop_front();
      end else begin
        mOut  = 1'b0;
        mBusy = 1'b0;
        mDone = 1'b1;
      end
    end else begin
      mDone = 1'b0;
      mOut  = 1'b0;
      if (set) begin
        frameQ.push_back(1'b1);
        frameQ.push_back(1'b1);
        frameQ.push_back(1'b0);
        frameQ.push_back(1'b1);
        for (int i = 7; i >= 0; i--) frameQ.push_back(data[i]);
`ifdef SEQ_1101_TX_PARITY_EN
        frameQ.push_back(^data);
`endif
        mOut  = frameQ.pop_front();
        mBusy = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    set  = s;
    data = d;
  endtask

  task automatic clearCapture();
    capBits   = 16'd0;
    capLen    = 0;
    doneCount = 0;
  endtask

  // Runs one clock cycle. Inputs change on the falling edge, and outputs are
  // sampled 1 time unit after the rising edge.
  task automatic tick(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput({tag, ".out"},  out,  mOut);
    checkOutput({tag, ".busy"}, busy, mBusy);
    checkOutput({tag, ".done"}, done, mDone);
    if (busy === 1'b1) begin
      capBits = {capBits[14:0], out};
      capLen++;
    end
    if (done === 1'b1) doneCount++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset held for three cycles with set high: the line stays quiet.
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h5A);
    repeat (3) tick("reset");

    // Release with set low: no frame may start on its own.
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h5A);
    clearCapture();
    repeat (3) tick("idle");
    checkCount("idle_busy_cycles", capLen, 0);

    // Single frame of A5 with a one-cycle set pulse.
    clearCapture();
    applyStimulus(1'b1, 8'hA5);
    tick("a5");
    applyStimulus(1'b0, 8'h00);
    repeat (FRAME_LEN + 3) tick("a5");
    checkWord("a5_bits", capBits, expFrame(8'hA5));
    checkCount("a5_busy_len", capLen, FRAME_LEN);
    checkCount("a5_done_pulses", doneCount, 1);

    // Payload 01: the parity bit is 1 when parity is enabled.
    clearCapture();
    applyStimulus(1'b1, 8'h01);
    tick("p01");
    applyStimulus(1'b0, 8'h01);
    repeat (FRAME_LEN + 3) tick("p01");
    checkWord("p01_bits", capBits, expFrame(8'h01));
    checkCount("p01_busy_len", capLen, FRAME_LEN);

    // A set pulse in cycle 5 of a frame, with new data, is ignored.
    clearCapture();
    applyStimulus(1'b1, 8'h96);
    tick("ign");
    applyStimulus(1'b0, 8'h96);
    repeat (3) tick("ign");
    applyStimulus(1'b1, 8'hFF);
    tick("ign");
    applyStimulus(1'b0, 8'hFF);
    repeat (FRAME_LEN + 3) tick("ign");
    checkWord("ign_bits", capBits, expFrame(8'h96));
    checkCount("ign_busy_len", capLen, FRAME_LEN);
    checkCount("ign_done_pulses", doneCount, 1);

    // Set held high: two frames separated by one idle bit.
    clearCapture();
    applyStimulus(1'b1, 8'h3C);
    repeat (FRAME_LEN + 2) tick("b2b");
    applyStimulus(1'b0, 8'h3C);
    repeat (FRAME_LEN + 3) tick("b2b");
    checkCount("b2b_busy_len", capLen, 2 * FRAME_LEN);
    checkCount("b2b_done_pulses", doneCount, 2);
    checkWord("b2b_last_bits", capBits & 16'h0FFF, expFrame(8'h3C) & 16'h0FFF);

    // Reset pulse during the third data bit drops the outputs without a clock edge.
    clearCapture();
    applyStimulus(1'b1, 8'hC3);
    tick("mrst");
    applyStimulus(1'b0, 8'hC3);
    repeat (6) tick("mrst");
    checkOutput("mrst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_async_out",  out,  1'b0);
    checkOutput("mrst_async_busy", busy, 1'b0);
    checkOutput("mrst_async_done", done, 1'b0);
    modelReset();
    doneCount = 0;
    tick("mrst_hold");
    rst_n = 1'b1;
    repeat (3) tick("mrst_after");
    checkCount("mrst_no_done", doneCount, 0);

    // The next request after the reset sends a complete frame.
    clearCapture();
    applyStimulus(1'b1, 8'h81);
    tick("post");
    applyStimulus(1'b0, 8'h81);
    repeat (FRAME_LEN + 3) tick("post");
    checkWord("post_bits", capBits, expFrame(8'h81));
    checkCount("post_done_pulses", doneCount, 1);

    // Random requests and payload changes, checked cycle by cycle against the model.
    repeat (400) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
